// File: rtl/adbg_ahb3_burst_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : adbg_ahb3_burst_ctrl_if
// Purpose  : Bundles the command, write-stream, read-stream, status and BIU
//            access signals of the AHB3 debug burst controller.
// Modports : slave  - the burst controller view
//              in : cmd_valid/rw/addr/word_size/count, wr_data/valid,
//                   rd_ready, biu_do, biu_rdy, biu_err
//              out: cmd_ready, wr_ready, rd_data/valid, busy, done,
//                   err_flag, err_addr, biu_strb/rw/addr/word_size/di
//            master - the surrounding logic (command source, BIU)
// Revision : 1.0 - initial release
// ============================================================================
interface adbg_ahb3_burst_ctrl_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
);

  // Command channel
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_rw;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [3:0]            cmd_word_size;
  logic [CNT_WIDTH-1:0]  cmd_count;

  // Write-data stream
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_valid;
  logic                  wr_ready;

  // Read-data stream
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  rd_ready;

  // Status
  logic                  busy;
  logic                  done;
  logic                  err_flag;
  logic [ADDR_WIDTH-1:0] err_addr;

  // BIU access port
  logic                  biu_strb;
  logic                  biu_rw;
  logic [ADDR_WIDTH-1:0] biu_addr;
  logic [3:0]            biu_word_size;
  logic [DATA_WIDTH-1:0] biu_di;
  logic [DATA_WIDTH-1:0] biu_do;
  logic                  biu_rdy;
  logic                  biu_err;

  modport slave (
    input  cmd_valid, cmd_rw, cmd_addr, cmd_word_size, cmd_count,
    output cmd_ready,
    input  wr_data, wr_valid,
    output wr_ready,
    output rd_data, rd_valid,
    input  rd_ready,
    output busy, done, err_flag, err_addr,
    output biu_strb, biu_rw, biu_addr, biu_word_size, biu_di,
    input  biu_do, biu_rdy, biu_err
  );

  modport master (
    output cmd_valid, cmd_rw, cmd_addr, cmd_word_size, cmd_count,
    input  cmd_ready,
    output wr_data, wr_valid,
    input  wr_ready,
    input  rd_data, rd_valid,
    output rd_ready,
    input  busy, done, err_flag, err_addr,
    input  biu_strb, biu_rw, biu_addr, biu_word_size, biu_di,
    output biu_do, biu_rdy, biu_err
  );

endinterface
`default_nettype wire

// File: rtl/adbg_ahb3_burst_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : adbg_ahb3_burst_ctrl
// Purpose  : Debug-clock-domain burst sequencer for the AHB3 debug BIU. Takes
//            one burst command (address, word size, count, direction), splits
//            it into single BIU accesses over the biu_strb/biu_rdy handshake,
//            streams write words in / read words out, and keeps a sticky bus
//            error flag with the address of the first failing access.
// Ports    : biu_clk - debug clock, all logic on its rising edge
//            biu_rst - synchronous active-high reset
//            bus     - adbg_ahb3_burst_ctrl_if.slave (command, write stream,
//                      read stream, status, BIU access signals)
// Revision : 1.0 - initial release
// ============================================================================
module adbg_ahb3_burst_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,   // 32 or 64
  parameter int CNT_WIDTH  = 16
) (
  input  logic                         biu_clk,
  input  logic                         biu_rst,
  adbg_ahb3_burst_ctrl_if.slave        bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WDATA = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_RDOUT = 3'd4,
    S_NEXT  = 3'd5,
    S_DONE  = 3'd6   // single-cycle end for empty or illegal bursts
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;

  logic                  r_rw;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [3:0]            r_size;
  logic [CNT_WIDTH-1:0]  r_count;
  logic [DATA_WIDTH-1:0] r_di;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  r_err;
  logic [ADDR_WIDTH-1:0] r_err_addr;
  logic                  r_wait_first;

  logic                  w_size_legal;
  logic                  w_last;
  logic                  w_rsp;
  logic [6:0]            w_wr_shift;
  logic [ADDR_WIDTH-1:0] w_size_ext;

  logic                  w_cmd_ready;
  logic                  w_wr_ready;
  logic                  w_strb;
  logic                  w_rd_valid;
  logic                  w_done;
  logic                  w_busy;

  // Legal access sizes; 8-byte accesses exist only on a 64-bit data path.
  always_comb begin
    w_size_legal = 1'b0;
    case (bus.cmd_word_size)
      4'd1, 4'd2, 4'd4: w_size_legal = 1'b1;
      4'd8:             w_size_legal = (DATA_WIDTH == 64);
      default:          w_size_legal = 1'b0;
    endcase
  end

  // Write words arrive LSB-justified; the BIU expects them in the top bytes.
  always_comb begin
    w_wr_shift = 7'd0;
    case (r_size)
      4'd1:    w_wr_shift = 7'(DATA_WIDTH - 8);
      4'd2:    w_wr_shift = 7'(DATA_WIDTH - 16);
      4'd4:    w_wr_shift = 7'(DATA_WIDTH - 32);
      default: w_wr_shift = 7'd0;
    endcase
  end

  assign w_size_ext = {{(ADDR_WIDTH-4){1'b0}}, r_size};
  assign w_last     = (r_count == {{(CNT_WIDTH-1){1'b0}}, 1'b1});
  // The BIU drops biu_rdy one cycle late, so the first WAIT cycle still sees
  // the stale ready from the accept cycle and must be skipped.
  assign w_rsp      = (r_state == S_WAIT) && !r_wait_first && bus.biu_rdy;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge biu_clk) begin
    if (biu_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and state-decoded outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_cmd_ready = 1'b0;
    w_wr_ready  = 1'b0;
    w_strb      = 1'b0;
    w_rd_valid  = 1'b0;
    w_done      = 1'b0;
    w_busy      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cmd_ready = 1'b1;
        if (bus.cmd_valid) begin
          if (!w_size_legal || (bus.cmd_count == '0)) begin
            w_state_nxt = S_DONE;
          end else if (bus.cmd_rw) begin
            w_state_nxt = S_ISSUE;
          end else begin
            w_state_nxt = S_WDATA;
          end
        end
      end
      S_WDATA: begin
        w_wr_ready = 1'b1;
        w_busy     = 1'b1;
        if (bus.wr_valid) begin
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_strb = 1'b1;
        w_busy = 1'b1;
        if (bus.biu_rdy) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        w_busy = 1'b1;
        if (w_rsp) begin
          w_state_nxt = r_rw ? S_RDOUT : S_NEXT;
        end
      end
      S_RDOUT: begin
        w_rd_valid = 1'b1;
        w_busy     = 1'b1;
        if (bus.rd_ready) begin
          w_state_nxt = S_NEXT;
        end
      end
      S_NEXT: begin
        w_done = w_last;
        w_busy = !w_last;
        if (w_last) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = r_rw ? S_ISSUE : S_WDATA;
        end
      end
      S_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Burst datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge biu_clk) begin
    if (biu_rst) begin
      r_rw         <= 1'b0;
      r_addr       <= '0;
      r_size       <= 4'd0;
      r_count      <= '0;
      r_di         <= '0;
      r_rd_data    <= '0;
      r_err        <= 1'b0;
      r_err_addr   <= '0;
      r_wait_first <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            r_rw       <= bus.cmd_rw;
            r_addr     <= bus.cmd_addr;
            r_size     <= bus.cmd_word_size;
            r_count    <= bus.cmd_count;
            // A new command restarts error tracking; an illegal size is
            // itself reported as an error at the start address.
            r_err      <= !w_size_legal;
            r_err_addr <= w_size_legal ? '0 : bus.cmd_addr;
          end
        end
        S_WDATA: begin
          if (bus.wr_valid) begin
            r_di <= bus.wr_data << w_wr_shift;
          end
        end
        S_ISSUE: begin
          r_wait_first <= 1'b1;
        end
        S_WAIT: begin
          r_wait_first <= 1'b0;
          if (w_rsp) begin
            if (bus.biu_err && !r_err) begin
              r_err      <= 1'b1;
              r_err_addr <= r_addr;
            end
            if (r_rw) begin
              r_rd_data <= bus.biu_do;
            end
          end
        end
        S_NEXT: begin
          r_count <= r_count - 1'b1;
          r_addr  <= r_addr + w_size_ext;   // wraps modulo 2^ADDR_WIDTH
        end
        default: begin
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Output drive
  // --------------------------------------------------------------------------
  assign bus.cmd_ready     = w_cmd_ready;
  assign bus.wr_ready      = w_wr_ready;
  assign bus.rd_valid      = w_rd_valid;
  assign bus.rd_data       = r_rd_data;
  assign bus.busy          = w_busy;
  assign bus.done          = w_done;
  assign bus.err_flag      = r_err;
  assign bus.err_addr      = r_err_addr;
  assign bus.biu_strb      = w_strb;
  assign bus.biu_rw        = r_rw;
  assign bus.biu_addr      = r_addr;
  assign bus.biu_word_size = r_size;
  assign bus.biu_di        = r_di;

endmodule
`default_nettype wire

// File: tb/tb_adbg_ahb3_burst_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_adbg_ahb3_burst_ctrl
// Purpose  : Self-checking bench for adbg_ahb3_burst_ctrl. A toggle-style BIU
//            model with programmable round trip logs every accepted access;
//            expected accesses, read words and error status are computed per
//            burst from the command with plain address/data arithmetic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adbg_ahb3_burst_ctrl;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  adbg_ahb3_burst_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

  adbg_ahb3_burst_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .biu_clk (clk),
    .biu_rst (rst),
    .bus     (bus)
  );

  int vectors    = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // BIU model: accepts on strb && rdy, drops rdy, returns rdy after rt cycles
  // with the next scripted {err, data} response.
  // --------------------------------------------------------------------------
  logic        m_rdy = 1'b1;
  logic [31:0] m_do  = 32'h0;
  logic        m_err = 1'b0;
  int          rt = 5;
  int          rt_cnt = 0;
  logic        acc_prev = 1'b0;
  int          strb_viol = 0;
  logic [32:0] resp_q[$];
  logic [31:0] acc_addr_q[$];
  logic [31:0] acc_di_q[$];
  logic        acc_rw_q[$];
  logic [3:0]  acc_size_q[$];

  assign bus.biu_rdy = m_rdy;
  assign bus.biu_do  = m_do;
  assign bus.biu_err = m_err;

  always @(posedge clk) begin
    logic [32:0] r;
    if (acc_prev && bus.biu_strb) strb_viol <= strb_viol + 1;
    acc_prev <= 1'b0;
    if (bus.biu_strb && m_rdy) begin
      acc_prev <= 1'b1;
      acc_addr_q.push_back(bus.biu_addr);
      acc_di_q.push_back(bus.biu_di);
      acc_rw_q.push_back(bus.biu_rw);
      acc_size_q.push_back(bus.biu_word_size);
      r = (resp_q.size() > 0) ? resp_q.pop_front() : 33'h0;
      m_do   <= r[31:0];
      m_err  <= r[32];
      m_rdy  <= 1'b0;
      rt_cnt <= rt;
    end else if (!m_rdy) begin
      if (rt_cnt <= 1) m_rdy <= 1'b1;
      else             rt_cnt <= rt_cnt - 1;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  // --------------------------------------------------------------------------
  // One burst: drive command, feed/consume streams, then compare against the
  // expected access list built from start address, size and count.
  // --------------------------------------------------------------------------
  logic [31:0] wdata_q[$];

  task automatic run_burst(input logic rw, input logic [31:0] addr, input logic [3:0] size,
                           input int count, input int stall_word, input int stall_len);
    bit          legal;
    int          n_acc, base, widx, cyc, dones, busy_bad, stall_left;
    logic        exp_err;
    logic [31:0] exp_eaddr, a, stall_val, exp_di;
    logic [32:0] rsp[$];
    logic [31:0] got[$];
    bit          stalled, go;

    legal     = (size == 4'd1) || (size == 4'd2) || (size == 4'd4);
    n_acc     = legal ? count : 0;
    rsp       = resp_q;
    exp_err   = !legal;
    exp_eaddr = legal ? 32'h0 : addr;
    for (int i = 0; i < n_acc; i++) begin
      a = addr + 32'(i) * 32'(size);
      if (i < rsp.size() && rsp[i][32] && !exp_err) begin
        exp_err   = 1'b1;
        exp_eaddr = a;
      end
    end

    base = acc_addr_q.size();
    widx = 0; dones = 0; busy_bad = 0; stalled = 0; stall_left = stall_len;
    stall_val = 32'h0;

    @(negedge clk);
    check("cmd_ready_idle", 64'(bus.cmd_ready), 64'd1);
    bus.cmd_rw        = rw;
    bus.cmd_addr      = addr;
    bus.cmd_word_size = size;
    bus.cmd_count     = CW'(count);
    bus.cmd_valid     = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    check("err_at_accept", 64'(bus.err_flag), 64'(!legal));
    check("done_first_cycle", 64'(bus.done), 64'(n_acc == 0));

    cyc = 0;
    while (cyc < 1000) begin
      if (bus.done) begin
        dones++;
        if (bus.busy) busy_bad++;
        break;
      end
      if (!bus.busy) busy_bad++;
      // Commands while busy must be ignored.
      bus.cmd_valid     = ($urandom_range(0, 5) == 0);
      bus.cmd_addr      = $urandom;
      bus.cmd_rw        = 1'($urandom_range(0, 1));
      bus.cmd_word_size = 4'd4;
      bus.cmd_count     = CW'($urandom_range(1, 3));
      // Write stream; wr_valid outside WDATA must be ignored.
      if (bus.wr_ready) begin
        if ($urandom_range(0, 3) != 0) begin
          bus.wr_valid = 1'b1;
          bus.wr_data  = (widx < wdata_q.size()) ? wdata_q[widx] : 32'hDEAD0000;
          widx++;
        end else begin
          bus.wr_valid = 1'b0;
          bus.wr_data  = $urandom;
        end
      end else begin
        bus.wr_valid = 1'($urandom_range(0, 1));
        bus.wr_data  = $urandom;
      end
      // Read stream with random and directed stalls.
      if (bus.rd_valid) begin
        if (stalled) check("rd_data_stable", 64'(bus.rd_data), 64'(stall_val));
        if (got.size() == stall_word && stall_left > 0) begin
          go = 0;
          stall_left--;
        end else begin
          go = ($urandom_range(0, 3) != 0);
        end
        if (go) begin
          bus.rd_ready = 1'b1;
          got.push_back(bus.rd_data);
          stalled = 0;
        end else begin
          bus.rd_ready = 1'b0;
          stalled   = 1;
          stall_val = bus.rd_data;
        end
      end else begin
        bus.rd_ready = 1'($urandom_range(0, 1));
        stalled = 0;
      end
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 1000) check("burst_timeout", 64'd1, 64'd0);
    bus.cmd_valid = 1'b0;
    bus.wr_valid  = 1'b0;
    bus.rd_ready  = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (bus.done) dones++;
    end

    check("done_once", 64'(dones), 64'd1);
    check("busy_window", 64'(busy_bad), 64'd0);
    check("access_count", 64'(acc_addr_q.size() - base), 64'(n_acc));
    check("strb_after_accept", 64'(strb_viol), 64'd0);
    check("wr_words_taken", 64'(widx), rw ? 64'd0 : 64'(n_acc));
    for (int i = 0; i < n_acc && (base + i) < acc_addr_q.size(); i++) begin
      a = addr + 32'(i) * 32'(size);
      check("biu_addr", 64'(acc_addr_q[base+i]), 64'(a));
      check("biu_rw", 64'(acc_rw_q[base+i]), 64'(rw));
      check("biu_word_size", 64'(acc_size_q[base+i]), 64'(size));
      if (!rw && i < wdata_q.size()) begin
        // Low 'size' bytes of the word, moved to the top of the 32-bit bus.
        exp_di = 32'((64'(wdata_q[i]) % (64'd1 << (8 * size))) * (64'd1 << (32 - 8 * size)));
        check("biu_di", 64'(acc_di_q[base+i]), 64'(exp_di));
      end
    end
    if (rw && legal) begin
      check("rd_word_count", 64'(got.size()), 64'(n_acc));
      for (int i = 0; i < n_acc && i < got.size() && i < rsp.size(); i++)
        check("rd_data", 64'(got[i]), 64'(rsp[i][31:0]));
    end
    check("err_flag", 64'(bus.err_flag), 64'(exp_err));
    check("err_addr", 64'(bus.err_addr), 64'(exp_eaddr));
    resp_q.delete();
  endtask

  // --------------------------------------------------------------------------
  // Directed sequence followed by random bursts
  // --------------------------------------------------------------------------
  initial begin
    int          n0, cyc, cnt, sel;
    logic [3:0]  sz;
    logic        rw;
    logic [31:0] ad;

    bus.cmd_valid = 1'b0; bus.cmd_rw = 1'b0; bus.cmd_addr = '0;
    bus.cmd_word_size = 4'd0; bus.cmd_count = '0;
    bus.wr_data = '0; bus.wr_valid = 1'b0; bus.rd_ready = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_err_flag", 64'(bus.err_flag), 64'd0);
    check("rst_err_addr", 64'(bus.err_addr), 64'd0);
    check("rst_biu_strb", 64'(bus.biu_strb), 64'd0);
    check("rst_rd_valid", 64'(bus.rd_valid), 64'd0);
    check("rst_wr_ready", 64'(bus.wr_ready), 64'd0);
    check("rst_biu_di", 64'(bus.biu_di), 64'd0);
    check("rst_biu_addr", 64'(bus.biu_addr), 64'd0);
    rst = 1'b0;

    // 4-word write, 5-cycle BIU round trip
    rt = 5;
    wdata_q = {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    repeat (4) resp_q.push_back(33'h0);
    run_burst(1'b0, 32'h1000, 4'd4, 4, -1, 0);

    // 3-word byte read with a 10-cycle consumer stall on word 2
    wdata_q.delete();
    resp_q.push_back({1'b0, 32'h000000A5});
    resp_q.push_back({1'b0, 32'h0000005A});
    resp_q.push_back({1'b0, 32'h000000FF});
    run_burst(1'b1, 32'h2001, 4'd1, 3, 1, 10);

    // 4-word read, errors on words 2 and 4
    resp_q.push_back({1'b0, 32'hA0A0A0A0});
    resp_q.push_back({1'b1, 32'hB1B1B1B1});
    resp_q.push_back({1'b0, 32'hC2C2C2C2});
    resp_q.push_back({1'b1, 32'hD3D3D3D3});
    run_burst(1'b1, 32'h3000, 4'd4, 4, -1, 0);
    check("err_addr_first_error", 64'(bus.err_addr), 64'h3004);

    // Halfword write: data lands in the top half of biu_di
    wdata_q = {32'h0000BEEF};
    resp_q.push_back(33'h0);
    run_burst(1'b0, 32'h4000, 4'd2, 1, -1, 0);
    check("halfword_di", 64'(acc_di_q[acc_di_q.size()-1]), 64'hBEEF0000);

    // Illegal size 3 and illegal size 8 on a 32-bit bus
    wdata_q.delete();
    run_burst(1'b0, 32'h4100, 4'd3, 2, -1, 0);
    run_burst(1'b1, 32'h4200, 4'd8, 1, -1, 0);

    // Address wrap
    wdata_q = {32'h01234567, 32'h89ABCDEF};
    repeat (2) resp_q.push_back(33'h0);
    run_burst(1'b0, 32'hFFFFFFFC, 4'd4, 2, -1, 0);
    check("wrap_addr", 64'(acc_addr_q[acc_addr_q.size()-1]), 64'h0);

    // Zero-length burst
    wdata_q.delete();
    run_burst(1'b1, 32'h7000, 4'd4, 0, -1, 0);

    // Reset while the BIU is mid-access
    rt = 20;
    resp_q.push_back({1'b0, 32'hCAFEF00D});
    n0 = acc_addr_q.size();
    @(negedge clk);
    bus.cmd_rw = 1'b1; bus.cmd_addr = 32'h5000; bus.cmd_word_size = 4'd4;
    bus.cmd_count = CW'(2); bus.cmd_valid = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    cyc = 0;
    while (acc_addr_q.size() == n0 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("rst_test_first_accept", 64'(acc_addr_q.size() - n0), 64'd1);
    repeat (3) @(negedge clk);
    check("biu_busy_before_rst", 64'(m_rdy), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_biu_strb", 64'(bus.biu_strb), 64'd0);
    check("midrst_rd_valid", 64'(bus.rd_valid), 64'd0);
    check("midrst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    check("midrst_busy", 64'(bus.busy), 64'd0);
    rst = 1'b0;
    resp_q.delete();
    rt = 5;
    resp_q.push_back({1'b0, 32'h12345678});
    run_burst(1'b1, 32'h6000, 4'd4, 1, -1, 0);

    // Random bursts
    for (int k = 0; k < 10; k++) begin
      rt  = $urandom_range(1, 6);
      rw  = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 6);
      case (sel)
        0:       sz = 4'd1;
        1:       sz = 4'd2;
        2, 3:    sz = 4'd4;
        4:       sz = 4'd8;
        default: sz = 4'($urandom_range(0, 15));
      endcase
      cnt = $urandom_range(0, 5);
      ad  = $urandom;
      wdata_q.delete();
      for (int i = 0; i < cnt; i++) wdata_q.push_back($urandom);
      if (sz == 4'd1 || sz == 4'd2 || sz == 4'd4)
        for (int i = 0; i < cnt; i++)
          resp_q.push_back({1'($urandom_range(0, 3) == 0), 32'($urandom)});
      run_burst(rw, ad, sz, cnt, $urandom_range(0, 4), $urandom_range(0, 6));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
